// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state enum, latency limit and error read value.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned LAT_MAX = 15;
  localparam logic [31:0] ERR_RDATA = 32'h0;

  // Misaligned or outside [base, base + depth*4); wrap below base is out.
  function automatic logic addr_err(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int unsigned depth
  );
    logic [31:0] off;
    logic [32:0] lim;
    off = addr - base;
    lim = 33'(depth) << 2;
    return (addr[1:0] != 2'b00) || ({1'b0, off} >= lim);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between an initiator and the responder.
// The initiator drives the strobe side, the responder the ack side.
interface dmem_responder_if;

  logic        i_stb;
  logic        i_wr_en;
  logic [31:0] i_addr;
  logic [31:0] i_wr_data;
  logic        o_ack;
  logic [31:0] o_rd_data;
  logic        o_err;
  logic        o_busy;

  modport master (
    output i_stb,
    output i_wr_en,
    output i_addr,
    output i_wr_data,
    input  o_ack,
    input  o_rd_data,
    input  o_err,
    input  o_busy
  );

  modport slave (
    input  i_stb,
    input  i_wr_en,
    input  i_addr,
    input  i_wr_data,
    output o_ack,
    output o_rd_data,
    output o_err,
    output o_busy
  );

endinterface

// File: rtl/dmem_ram.sv
// Single-port word storage, synchronous write, registered read.
// Contents are never reset; the read register only moves on re.
module dmem_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write port and registered read port share one address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with range/alignment checking.
// One request in flight; ack is a registered pulse after RESP.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_LD =
    (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e        state_q;
  state_e        state_d;
  logic [3:0]    cnt_q;
  logic [3:0]    cnt_d;
  logic          cap;

  logic          wr_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;

  logic          ack_q;
  logic          err_q;
  logic          rd_zero_q;

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          req_err;
  logic          in_resp;
  logic          ram_we;
  logic          ram_re;
  logic [31:0]   ram_rdata;

  assign off     = addr_q - BASE_ADDR;
  assign idx     = AW'(off >> 2);
  assign req_err = addr_err(addr_q, BASE_ADDR, DEPTH);
  assign in_resp = (state_q == RESP);
  assign ram_we  = in_resp && wr_q && !req_err && rst_n;
  assign ram_re  = in_resp && !wr_q && !req_err;

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (idx),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Next state, wait counter and request capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_stb) begin
          cap = 1'b1;
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = LAT_LD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, captured request and held response flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= in_resp;
      if (cap) begin
        wr_q    <= bus.i_wr_en;
        addr_q  <= bus.i_addr;
        wdata_q <= bus.i_wr_data;
      end
      if (in_resp) begin
        err_q <= req_err;
        if (req_err) begin
          rd_zero_q <= 1'b1;
        end else if (!wr_q) begin
          rd_zero_q <= 1'b0;
        end
      end
    end
  end

  assign bus.o_ack     = ack_q;
  assign bus.o_err     = err_q;
  assign bus.o_busy    = (state_q != IDLE);
  assign bus.o_rd_data = rd_zero_q ? ERR_RDATA : ram_rdata;

endmodule
